// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder that reuses one DIGIT-bit ripple slice, LSB chunk first.
// Optional subtract support is enabled by defining CSA_SUB_EN.
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_sel;
    logic             accept;
    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] s;
    logic             c, c_msb;

`ifdef CSA_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign accept = start & ~flush & (state_q != RUN);

    // One DIGIT-wide ripple slice, steered onto the current chunk by shifting.
    always_comb begin
        base  = 32'(cnt_q) * DIGIT;
        a_sh  = a_q >> base;
        b_sh  = b_q >> base;
        s     = '0;
        c     = carry_q;
        c_msb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = c;
            s[i] = a_sh[i] ^ b_sh[i] ^ c;
            c    = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub_sel ? ~b : b;
            carry_d = sub_sel ? 1'b1 : cin;
            cnt_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    sum_d   = (sum_q & ~(MASK << base))
                            | (WIDTH'(s) << base);
                    carry_d = c;
                    if (cnt_q == CW'(NCHUNK - 1)) begin
                        state_d = DONE;
                        cout_d  = c;
                        ovf_d   = c ^ c_msb;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder (W32/D4 and W32/D32 instances).
// Subtract vectors run only when CSA_SUB_EN is defined.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, cin;
    logic [31:0] a, b;
    logic        busy, done, cout, ovf;
    logic [31:0] sum;
`ifdef CSA_SUB_EN
    logic        sub;
`endif

    logic        start32, cin32;
    logic [31:0] a32, b32;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    chunked_serial_adder #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start32),
        .flush (1'b0),
        .a     (a32),
        .b     (b32),
        .cin   (cin32),
`ifdef CSA_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy32),
        .done  (done32),
        .sum   (sum32),
        .cout  (cout32),
        .ovf   (ovf32)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, then count busy cycles until busy drops (bounded).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic ts,
                          output int ncyc);
        a = ta;
        b = tb_;
        cin = tc;
`ifdef CSA_SUB_EN
        sub = ts;
`else
        if (ts) $display("note: sub requested in add-only build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        ncyc = 0;
        while (busy && ncyc < 50) begin
            ncyc++;
            tick();
        end
    endtask

    int n, cyc, nd, last;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        cin = 1'b0;
        a = '0;
        b = '0;
`ifdef CSA_SUB_EN
        sub = 1'b0;
`endif
        start32 = 1'b0;
        cin32 = 1'b0;
        a32 = '0;
        b32 = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, n);
        chk("wrap_cycles", 64'(n), 64'd8);
        chk("wrap_done", 64'(done), 64'd1);
        chk("wrap_sum", 64'(sum), 64'h0);
        chk("wrap_cout", 64'(cout), 64'd1);
        chk("wrap_ovf", 64'(ovf), 64'd0);
        tick();
        chk("wrap_done_pulse", 64'(done), 64'd0);

        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, n);
        chk("ovf_sum", 64'(sum), 64'h8000_0000);
        chk("ovf_cout", 64'(cout), 64'd0);
        chk("ovf_ovf", 64'(ovf), 64'd1);
        tick();

        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, n);
        chk("cin_sum", 64'(sum), 64'h2345_678A);
        chk("cin_cout", 64'(cout), 64'd0);
        tick();

        a32 = 32'd5;
        b32 = 32'd3;
        cin32 = 1'b1;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        chk("d32_busy", 64'(busy32), 64'd1);
        tick();
        chk("d32_done", 64'(done32), 64'd1);
        chk("d32_sum", 64'(sum32), 64'd9);
        chk("d32_cout", 64'(cout32), 64'd0);
        chk("d32_ovf", 64'(ovf32), 64'd0);
        tick();

        // start held high: ops 1+1, 2+2, 3+3 back to back
        a = 32'd1;
        b = 32'd1;
        cin = 1'b0;
        start = 1'b1;
        tick();
        a = 32'd2;
        b = 32'd2;
        cyc = 0;
        nd = 0;
        last = 0;
        while (nd < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done) begin
                chk("b2b_sum", 64'(sum), 64'(2 * (nd + 1)));
                if (nd == 0) chk("b2b_first", 64'(cyc), 64'd8);
                else chk("b2b_space", 64'(cyc - last), 64'd9);
                last = cyc;
                nd++;
                if (nd == 3) start = 1'b0;
            end else begin
                a = 32'(nd + 2);
                b = 32'(nd + 2);
            end
        end
        chk("b2b_count", 64'(nd), 64'd3);
        start = 1'b0;
        tick();
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        chk("b2b_idle_done", 64'(done), 64'd0);

        // flush sampled at E0+4
        a = 32'hFFFF_FFFF;
        b = 32'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_partial", 64'(sum[11:0]), 64'h0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) nd++;
            tick();
        end
        chk("flush_no_done", 64'(nd), 64'd0);
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, n);
        chk("flush_next_sum", 64'(sum), 64'hFFFF_FFFF);
        chk("flush_next_cout", 64'(cout), 64'd0);
        tick();

        // reset asserted mid-operation
        a = 32'hFFFF_FFFF;
        b = 32'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_sum", 64'(sum), 64'd0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) nd++;
            tick();
        end
        chk("arst_no_done", 64'(nd), 64'd0);
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, n);
        chk("arst_next_sum", 64'(sum), 64'hFFFF_FFFF);
        chk("arst_next_cout", 64'(cout), 64'd0);
        tick();

`ifdef CSA_SUB_EN
        run_op(32'd3, 32'd5, 1'b0, 1'b1, n);
        chk("sub_sum", 64'(sum), 64'hFFFF_FFFE);
        chk("sub_cout", 64'(cout), 64'd0);
        chk("sub_ovf", 64'(ovf), 64'd0);
        tick();
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, n);
        chk("subo_sum", 64'(sum), 64'h7FFF_FFFF);
        chk("subo_cout", 64'(cout), 64'd1);
        chk("subo_ovf", 64'(ovf), 64'd1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
